// File: rtl/eviction_write_buffer.sv
// eviction_write_buffer: coalescing FIFO of evicted dirty lines with read-miss forwarding
module eviction_write_buffer #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wb_write,
  input  logic [15:0]  wb_addr,
  input  logic [127:0] wb_wdata,
  output logic         wb_full,
  input  logic [15:0]  rd_addr,
  output logic         rd_hit,
  output logic [127:0] rd_hit_data,
  output logic         wb_pending,
  input  logic         wr_grant,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;
  logic [DEPTH-1:0] valid;
  logic [11:0]      laddr [DEPTH];
  logic [127:0]     data  [DEPTH];
  logic [PW-1:0]    head, tail, idx, csel, fsel;
  logic [CW-1:0]    count;
  logic [0:0]       state;
  logic             chit, fhit, app, pop;
  logic             unused_low;
  assign unused_low   = ^{wb_addr[3:0], rd_addr[3:0]};
  assign wb_full      = count == CW'(DEPTH);
  assign wb_pending   = count != '0;
  assign pmem_write   = state == WRITE;
  assign pmem_address = {laddr[head], 4'b0};
  assign pmem_wdata   = data[head];
  assign rd_hit       = fhit;
  assign rd_hit_data  = fhit ? data[fsel] : '0;
  assign app          = wb_write && !chit && !wb_full;
  assign pop          = (state == WRITE) && pmem_resp;
  // Walk head->tail so the last match found is the newest entry; the in-flight head is never a coalesce target
  always_comb begin
    idx  = head;
    csel = '0;
    chit = 1'b0;
    fsel = '0;
    fhit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && laddr[idx] == wb_addr[15:4] && !(state == WRITE && idx == head)) begin
        chit = wb_write;
        csel = idx;
      end
      if (valid[idx] && laddr[idx] == rd_addr[15:4]) begin
        fhit = 1'b1;
        fsel = idx;
      end
    end
  end
  // FIFO storage, pointers, count and write FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (chit) data[csel] <= wb_wdata;
      if (app) begin
        valid[tail] <= 1'b1;
        laddr[tail] <= wb_addr[15:4];
        data[tail]  <= wb_wdata;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count + CW'(app) - CW'(pop);
      state <= (state == IDLE) ? ((wb_pending && wr_grant) ? WRITE : IDLE) : (pmem_resp ? IDLE : WRITE);
    end
  end
endmodule

// File: tb/tb_eviction_write_buffer.sv
// tb_eviction_write_buffer: table-driven directed check of the eviction write buffer (DEPTH=2)
module tb_eviction_write_buffer;
  logic         clk = 1'b0;
  logic         reset, wb_write, wr_grant, pmem_resp;
  logic [15:0]  wb_addr, rd_addr;
  logic [127:0] wb_wdata;
  logic         wb_full, rd_hit, wb_pending, pmem_write;
  logic [127:0] rd_hit_data, pmem_wdata;
  logic [15:0]  pmem_address;
  int n_vec = 0;
  int n_bad = 0;

  eviction_write_buffer #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .wb_write(wb_write), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_full(wb_full), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_hit_data(rd_hit_data),
    .wb_pending(wb_pending), .wr_grant(wr_grant), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, w; logic [15:0] a; logic [127:0] d; logic [15:0] ra; logic g, resp;
    logic full, hit; logic [127:0] hd; logic pend, pw; logic [15:0] pa; logic [127:0] pd;
  } vec_t;

  localparam logic [127:0] DA = {4{32'hAAAA_0001}};
  localparam logic [127:0] DB = {4{32'hBBBB_0002}};
  localparam logic [127:0] DC = {4{32'hCCCC_0003}};
  localparam logic [127:0] DD = {4{32'hDDDD_0004}};
  localparam logic [127:0] DE = {4{32'hEEEE_0005}};
  localparam logic [127:0] DF = {4{32'hFFFF_0006}};

  vec_t v[$];

  function automatic vec_t mk(logic rst, logic w, logic [15:0] a, logic [127:0] d, logic [15:0] ra,
                              logic g, logic resp, logic full, logic hit, logic [127:0] hd,
                              logic pend, logic pw, logic [15:0] pa, logic [127:0] pd);
    vec_t r;
    r.rst = rst; r.w = w; r.a = a; r.d = d; r.ra = ra; r.g = g; r.resp = resp;
    r.full = full; r.hit = hit; r.hd = hd; r.pend = pend; r.pw = pw; r.pa = pa; r.pd = pd;
    return r;
  endfunction

  task automatic check(string name, logic full, logic hit, logic [127:0] hd, logic pend, logic pw,
                       logic [15:0] pa, logic [127:0] pd);
    logic ok;
    ok = wb_full === full && rd_hit === hit && rd_hit_data === hd && wb_pending === pend &&
         pmem_write === pw && (!pw || (pmem_address === pa && pmem_wdata === pd));
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got full=%b hit=%b hd=%h pend=%b pw=%b pa=%h pd=%h exp full=%b hit=%b hd=%h pend=%b pw=%b pa=%h pd=%h",
               name, wb_full, rd_hit, rd_hit_data, wb_pending, pmem_write, pmem_address, pmem_wdata,
               full, hit, hd, pend, pw, pa, pd);
    end
  endtask

  initial begin
    //             rst w  addr     data ra       g  resp  full hit hd   pend pw pa       pd
    v.push_back(mk(1, 0, 16'h0000, 0,  16'h1230, 0, 0,    0,   0,  0,   0,   0, 16'h0,   0));
    v.push_back(mk(0, 1, 16'h1230, DA, 16'h1230, 0, 0,    0,   1,  DA,  1,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h1230, 1, 0,    0,   1,  DA,  1,   1, 16'h1230, DA));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h1230, 0, 0,    0,   1,  DA,  1,   1, 16'h1230, DA));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h1230, 0, 0,    0,   1,  DA,  1,   1, 16'h1230, DA));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h1230, 0, 1,    0,   0,  0,   0,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h1230, 0, 1,    0,   0,  0,   0,   0, 16'h0,   0));
    v.push_back(mk(0, 1, 16'h1000, DB, 16'h2000, 0, 0,    0,   0,  0,   1,   0, 16'h0,   0));
    v.push_back(mk(0, 1, 16'h2000, DC, 16'h2000, 0, 0,    1,   1,  DC,  1,   0, 16'h0,   0));
    v.push_back(mk(0, 1, 16'h3000, DD, 16'h3000, 0, 0,    1,   0,  0,   1,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h3000, 1, 0,    1,   0,  0,   1,   1, 16'h1000, DB));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h1000, 0, 1,    0,   0,  0,   1,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h2000, 1, 0,    0,   1,  DC,  1,   1, 16'h2000, DC));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h2000, 0, 1,    0,   0,  0,   0,   0, 16'h0,   0));
    v.push_back(mk(0, 1, 16'h4000, DB, 16'h500A, 0, 0,    0,   0,  0,   1,   0, 16'h0,   0));
    v.push_back(mk(0, 1, 16'h5000, DC, 16'h500A, 0, 0,    1,   1,  DC,  1,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h6000, 0, 0,    1,   0,  0,   1,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h4004, 0, 0,    1,   1,  DB,  1,   0, 16'h0,   0));
    v.push_back(mk(0, 1, 16'h5003, DD, 16'h5000, 0, 0,    1,   1,  DD,  1,   0, 16'h0,   0));
    v.push_back(mk(1, 0, 16'h0000, 0,  16'h5000, 0, 0,    0,   0,  0,   0,   0, 16'h0,   0));
    v.push_back(mk(0, 1, 16'h7000, DA, 16'h7000, 0, 0,    0,   1,  DA,  1,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h7000, 1, 0,    0,   1,  DA,  1,   1, 16'h7000, DA));
    v.push_back(mk(0, 1, 16'h7000, DD, 16'h7000, 0, 0,    1,   1,  DD,  1,   1, 16'h7000, DA));
    v.push_back(mk(0, 1, 16'h7000, DE, 16'h7000, 0, 0,    1,   1,  DE,  1,   1, 16'h7000, DA));
    v.push_back(mk(0, 1, 16'h7000, DF, 16'h7000, 0, 1,    0,   1,  DF,  1,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h7000, 1, 0,    0,   1,  DF,  1,   1, 16'h7000, DF));
    v.push_back(mk(1, 1, 16'h8000, DA, 16'h7000, 1, 1,    0,   0,  0,   0,   0, 16'h0,   0));
    v.push_back(mk(0, 0, 16'h0000, 0,  16'h7000, 0, 0,    0,   0,  0,   0,   0, 16'h0,   0));

    reset = 1'b1; wb_write = 1'b0; wb_addr = '0; wb_wdata = '0; rd_addr = '0; wr_grant = 1'b0; pmem_resp = 1'b0;
    @(posedge clk); #1;
    foreach (v[i]) begin
      reset = v[i].rst; wb_write = v[i].w; wb_addr = v[i].a; wb_wdata = v[i].d;
      rd_addr = v[i].ra; wr_grant = v[i].g; pmem_resp = v[i].resp;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), v[i].full, v[i].hit, v[i].hd, v[i].pend, v[i].pw, v[i].pa, v[i].pd);
    end

    reset = 1'b0; wb_write = 1'b1; wb_addr = 16'h9000; wb_wdata = DE; rd_addr = 16'h9008;
    wr_grant = 1'b0; pmem_resp = 1'b0;
    #1;
    check("push_not_forwarded_same_cycle", 0, 0, 0, 0, 0, 16'h0, 0);
    @(posedge clk); #1;
    wb_write = 1'b0;
    #1;
    check("push_forwarded_next_cycle", 0, 1, DE, 1, 0, 16'h0, 0);
    wr_grant = 1'b1;
    @(posedge clk); #1;
    wr_grant = 1'b0;
    check("latency_one_grant", 0, 1, DE, 1, 1, 16'h9000, DE);
    pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    check("pop_after_wrap", 0, 0, 0, 0, 0, 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
